// File: rtl/mux_stream_pkg.sv
// mux_stream_pkg: shared mode encodings and FSM state type for the stream mux.
package mux_stream_pkg;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority encoder, first request after ptr wins.
module rr_pick #(
    parameter int N_CH = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);
    logic [SEL_W-1:0] idx;

    // Scan farthest-first so the request nearest after ptr overwrites the rest.
    always_comb begin
        gnt_vld = |req;
        gnt_idx = '0;
        idx = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = SEL_W'((int'(ptr) + i) % N_CH);
            if (req[idx]) gnt_idx = idx;
        end
    end
endmodule

// File: rtl/mux_stream_rr.sv
// mux_stream_rr: N-channel valid/ready stream mux with manual or round-robin
// selection, packet locking and a single registered output stage.
module mux_stream_rr
    import mux_stream_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);
    state_t           state, state_nxt;
    logic [SEL_W-1:0] lock_ch, rr_ptr, rr_g, g;
    logic             lock_rr, rr_vld, rr_active, grant_vld, load_en, xfer, g_last;

    rr_pick #(.N_CH(N_CH)) u_pick (
        .req(in_valid),
        .ptr(rr_ptr),
        .gnt_idx(rr_g),
        .gnt_vld(rr_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = xfer ? (g_last ? ST_IDLE : ST_LOCKED) : state;
    end

    // While locked, the mode seen at packet start decides whether rr_ptr advances.
    always_comb begin
        load_en   = !out_valid | out_ready;
        rr_active = (state == ST_LOCKED) ? lock_rr : (mode == MODE_RR);
        g         = (state == ST_LOCKED) ? lock_ch : (mode == MODE_RR) ? rr_g : sel;
        grant_vld = (state == ST_LOCKED) | ((mode == MODE_RR) ? rr_vld : (int'(sel) < N_CH));
        xfer      = load_en & grant_vld & in_valid[g];
        g_last    = in_last[g];
        in_ready  = (load_en & grant_vld) ? N_CH'(1) << g : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_ch   <= '0;
            lock_rr   <= 1'b0;
            rr_ptr    <= SEL_W'(N_CH - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else begin
            if (xfer) begin
                lock_ch <= g;
                lock_rr <= rr_active;
            end
            if (xfer & g_last & rr_active) rr_ptr <= g;
            if (load_en) out_valid <= xfer;
            if (xfer) begin
                out_data <= in_data[int'(g)*WIDTH +: WIDTH];
                out_last <= g_last;
                out_ch   <= g;
            end
        end
    end
endmodule
